hazard_ctrl_unit: RTL and testbench

Hazard and forwarding controller for the 5-stage MIPS pipeline.
- Reads the ID- and EX-stage register fields that the ID/EX pipeline register consumes and produces.
- Drives the flush input of that register, plus F/D stalls and EX/ID forwarding selects.
- Adds a sequential multi-cycle multiply/divide interlock FSM, so that instructions behind a mul/div wait in D while bubbles enter E.

---
 rtl/hazard_ctrl_unit_pkg.sv | 27 ++
 rtl/hazard_ctrl_unit_if.sv | 32 +++
 rtl/hazard_ctrl_unit_md.sv | 52 +++++
 rtl/hazard_ctrl_unit.sv | 72 +++++++
 tb/tb_hazard_ctrl_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline constants: forward-select encodings, interlock FSM states, register $0.
// Imported by the hazard controller and its mul/div interlock.
package pipeline_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // MEM result is younger than WB, so it wins when both target the same source.
    function automatic logic [1:0] fwd_sel(
        input logic       regWriteM,
        input logic [4:0] writeRegM,
        input logic       regWriteW,
        input logic [4:0] writeRegW,
        input logic [4:0] src
    );
        if (regWriteM && writeRegM != REG_ZERO && writeRegM == src) return FWD_MEM;
        if (regWriteW && writeRegW != REG_ZERO && writeRegW == src) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-register fields in, stall/flush/forward controls out.
// Optional HAZARD_PERF_CNT_EN adds the stallCycles/mdCycles counter outputs.
interface hazard_ctrl_unit_if;
    logic [4:0] RsD, RtD, RsE, RtE, writeRegE, writeRegM, writeRegW;
    logic       branchD, regWriteE, memToRegE, mdStartE, mdOpE;
    logic       regWriteM, memToRegM, regWriteW;
    logic       stallF, stallD, hazardDetected, forwardAD, forwardBD, mdBusy;
    logic [1:0] forwardAE, forwardBE;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallCycles, mdCycles;
`endif

    modport master (
        output RsD, RtD, branchD, RsE, RtE, writeRegE, regWriteE, memToRegE,
               mdStartE, mdOpE, writeRegM, regWriteM, memToRegM, writeRegW, regWriteW,
        input  stallF, stallD, hazardDetected, forwardAE, forwardBE, forwardAD,
               forwardBD, mdBusy
`ifdef HAZARD_PERF_CNT_EN
        , input stallCycles, mdCycles
`endif
    );

    modport slave (
        input  RsD, RtD, branchD, RsE, RtE, writeRegE, regWriteE, memToRegE,
               mdStartE, mdOpE, writeRegM, regWriteM, memToRegM, writeRegW, regWriteW,
        output stallF, stallD, hazardDetected, forwardAE, forwardBE, forwardAD,
               forwardBD, mdBusy
`ifdef HAZARD_PERF_CNT_EN
        , output stallCycles, mdCycles
`endif
    );
endinterface

// File: rtl/hazard_ctrl_unit_md.sv
// Multi-cycle mul/div interlock: stalls D for MUL_LAT/DIV_LAT cycles counting the start cycle.
// mdStall is combinational; a new mdStartE is only honoured from IDLE.
module md_interlock
    import pipeline_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 12,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mdStartE,
    input  logic mdOpE,
    output logic mdStall,
    output logic mdBusy
);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] start_cnt;

    assign start_cnt = mdOpE ? DIV_CNT : MUL_CNT;
    assign mdBusy    = (state == BUSY);
    assign mdStall   = (state == BUSY) || (state == IDLE && mdStartE);

    // The start cycle itself is one stall, so BUSY only covers the remaining L-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdStartE && start_cnt != '0) begin
                        state <= BUSY;
                        cnt   <= start_cnt;
                    end
                end
                default: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline; outputs are combinational off inputs+state.
// Optional HAZARD_PERF_CNT_EN adds stallCycles/mdCycles counters.
module hazard_ctrl_unit
    import pipeline_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 12,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    hazard_ctrl_unit_if.slave hz
);
    logic lw_stall, br_stall, md_stall, md_busy, stall;
    logic br_dep_e, br_dep_m;

    md_interlock #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_md (
        .clk      (clk),
        .reset    (reset),
        .mdStartE (hz.mdStartE),
        .mdOpE    (hz.mdOpE),
        .mdStall  (md_stall),
        .mdBusy   (md_busy)
    );

    assign lw_stall = hz.memToRegE && (hz.RtE == hz.RsD || hz.RtE == hz.RtD);
    assign br_dep_e = hz.regWriteE && hz.writeRegE != REG_ZERO &&
                      (hz.writeRegE == hz.RsD || hz.writeRegE == hz.RtD);
    assign br_dep_m = hz.memToRegM && hz.writeRegM != REG_ZERO &&
                      (hz.writeRegM == hz.RsD || hz.writeRegM == hz.RtD);
    assign br_stall = hz.branchD && (br_dep_e || br_dep_m);
    assign stall    = lw_stall || br_stall || md_stall;

    // Reset keeps a bubble in ID/EX and silences everything else.
    always_comb begin
        hz.stallF         = 1'b0;
        hz.stallD         = 1'b0;
        hz.hazardDetected = 1'b1;
        hz.forwardAE      = FWD_RF;
        hz.forwardBE      = FWD_RF;
        hz.forwardAD      = 1'b0;
        hz.forwardBD      = 1'b0;
        hz.mdBusy         = 1'b0;
        if (!reset) begin
            hz.stallF         = stall;
            hz.stallD         = stall;
            hz.hazardDetected = stall;
            hz.forwardAE      = fwd_sel(hz.regWriteM, hz.writeRegM, hz.regWriteW, hz.writeRegW, hz.RsE);
            hz.forwardBE      = fwd_sel(hz.regWriteM, hz.writeRegM, hz.regWriteW, hz.writeRegW, hz.RtE);
            hz.forwardAD      = hz.regWriteM && hz.writeRegM != REG_ZERO && hz.writeRegM == hz.RsD;
            hz.forwardBD      = hz.regWriteM && hz.writeRegM != REG_ZERO && hz.writeRegM == hz.RtD;
            hz.mdBusy         = md_busy;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, md_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            md_cycles    <= '0;
        end else begin
            if (stall)    stall_cycles <= stall_cycles + 32'd1;
            if (md_stall) md_cycles    <= md_cycles + 32'd1;
        end
    end

    assign hz.stallCycles = stall_cycles;
    assign hz.mdCycles    = md_cycles;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: behavioural model checked every negedge plus directed literal checks.
module tb_hazard_ctrl_unit;
    localparam int MUL_L = 4;
    localparam int DIV_L = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_unit_if hz();

    hazard_ctrl_unit #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: md_left = stall cycles still owed after the current one.
    int          md_left = 0;
    logic [31:0] m_stall_cyc = 0;
    logic [31:0] m_md_cyc = 0;

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if (hz.regWriteM && hz.writeRegM != 0 && hz.writeRegM == r) return 2'd2;
        if (hz.regWriteW && hz.writeRegW != 0 && hz.writeRegW == r) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic m_md();
        return (md_left > 0) || hz.mdStartE;
    endfunction

    function automatic logic m_stall();
        logic lw, br;
        lw = hz.memToRegE && (hz.RtE == hz.RsD || hz.RtE == hz.RtD);
        br = hz.branchD &&
             ((hz.regWriteE && hz.writeRegE != 0 && (hz.writeRegE == hz.RsD || hz.writeRegE == hz.RtD)) ||
              (hz.memToRegM && hz.writeRegM != 0 && (hz.writeRegM == hz.RsD || hz.writeRegM == hz.RtD)));
        return lw || br || m_md();
    endfunction

    function automatic logic [9:0] m_outs();
        logic s;
        if (reset) return 10'b001_00_00_0_0_0;
        s = m_stall();
        return {s, s, s, m_fwd(hz.RsE), m_fwd(hz.RtE),
                hz.regWriteM && hz.writeRegM != 0 && hz.writeRegM == hz.RsD,
                hz.regWriteM && hz.writeRegM != 0 && hz.writeRegM == hz.RtD,
                md_left > 0};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            md_left     <= 0;
            m_stall_cyc <= 0;
            m_md_cyc    <= 0;
        end else begin
            if (m_stall()) m_stall_cyc <= m_stall_cyc + 1;
            if (m_md())    m_md_cyc    <= m_md_cyc + 1;
            if (md_left > 0)      md_left <= md_left - 1;
            else if (hz.mdStartE) md_left <= (hz.mdOpE ? DIV_L : MUL_L) - 1;
        end
    end

    function automatic logic [9:0] dut_outs();
        return {hz.stallF, hz.stallD, hz.hazardDetected, hz.forwardAE, hz.forwardBE,
                hz.forwardAD, hz.forwardBD, hz.mdBusy};
    endfunction

    always @(negedge clk) begin
        check("model_outputs", 32'(dut_outs()), 32'(m_outs()));
`ifdef HAZARD_PERF_CNT_EN
        check("model_stallCycles", hz.stallCycles, m_stall_cyc);
        check("model_mdCycles", hz.mdCycles, m_md_cyc);
`endif
    end

    task automatic clr();
        hz.RsD = 0; hz.RtD = 0; hz.branchD = 0; hz.RsE = 0; hz.RtE = 0;
        hz.writeRegE = 0; hz.regWriteE = 0; hz.memToRegE = 0; hz.mdStartE = 0; hz.mdOpE = 0;
        hz.writeRegM = 0; hz.regWriteM = 0; hz.memToRegM = 0; hz.writeRegW = 0; hz.regWriteW = 0;
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [4:0] rsd, rtd, input logic brd, input logic [4:0] rse, rte,
                         input logic [4:0] wre, input logic rwe, mre,
                         input logic [4:0] wrm, input logic rwm, mrm,
                         input logic [4:0] wrw, input logic rww);
        hz.RsD = rsd; hz.RtD = rtd; hz.branchD = brd; hz.RsE = rse; hz.RtE = rte;
        hz.writeRegE = wre; hz.regWriteE = rwe; hz.memToRegE = mre;
        hz.writeRegM = wrm; hz.regWriteM = rwm; hz.memToRegM = mrm;
        hz.writeRegW = wrw; hz.regWriteW = rww;
        to_next();
    endtask

    task automatic md_run(input logic op, input int lat);
        hz.mdStartE = 1'b1;
        hz.mdOpE    = op;
        for (int k = 0; k < lat + 2; k++) begin
            @(negedge clk);
            check(op ? "div_stall" : "mul_stall", 32'(hz.stallD), 32'(k < lat));
            check(op ? "div_busy" : "mul_busy", 32'(hz.mdBusy), 32'(k >= 1 && k < lat));
            to_next();
            hz.mdStartE = 1'b0;
        end
    endtask

    initial begin
        clr();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_hazard", 32'(hz.hazardDetected), 32'd1);
            check("rst_stalls", 32'({hz.stallF, hz.stallD}), 32'd0);
            check("rst_fwds", 32'({hz.forwardAE, hz.forwardBE}), 32'd0);
            to_next();
        end
        reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", 32'(dut_outs()), 32'd0);
        to_next();

        hz.memToRegE = 1; hz.RtE = 5; hz.RsD = 5;
        @(negedge clk);
        check("lw_stall", 32'({hz.stallF, hz.stallD, hz.hazardDetected}), 32'b111);
        to_next();
        clr();
        @(negedge clk);
        check("lw_release", 32'({hz.stallF, hz.stallD, hz.hazardDetected}), 32'b000);
        to_next();

        hz.regWriteM = 1; hz.writeRegM = 8; hz.regWriteW = 1; hz.writeRegW = 8; hz.RsE = 8;
        @(negedge clk);
        check("fwd_mem_prio", 32'(hz.forwardAE), 32'b10);
        to_next();
        hz.regWriteM = 0;
        @(negedge clk);
        check("fwd_wb", 32'(hz.forwardAE), 32'b01);
        to_next();
        hz.regWriteM = 1; hz.writeRegM = 0; hz.writeRegW = 0; hz.RsE = 0;
        @(negedge clk);
        check("fwd_zero_reg", 32'(hz.forwardAE), 32'b00);
        to_next();
        clr();

        hz.branchD = 1; hz.regWriteE = 1; hz.writeRegE = 3; hz.RtD = 3;
        @(negedge clk);
        check("br_stall", 32'(hz.stallD), 32'd1);
        to_next();
        hz.regWriteE = 0; hz.writeRegE = 0; hz.writeRegM = 3; hz.regWriteM = 1;
        @(negedge clk);
        check("br_fwdBD", 32'(hz.forwardBD), 32'd1);
        check("br_no_stall", 32'(hz.stallD), 32'd0);
        to_next();
        clr();

        md_run(1'b0, MUL_L);
        md_run(1'b1, DIV_L);

        // Reset lands on the 5th cycle of a divide.
        hz.mdStartE = 1; hz.mdOpE = 1;
        to_next();
        hz.mdStartE = 0;
        repeat (3) to_next();
        reset = 1'b1;
        @(negedge clk);
        check("mdrst_flush", 32'(hz.hazardDetected), 32'd1);
        check("mdrst_busy_masked", 32'(hz.mdBusy), 32'd0);
        to_next();
        reset = 1'b0;
        @(negedge clk);
        check("mdrst_idle", 32'({hz.mdBusy, hz.stallD}), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_clr", hz.stallCycles, 32'd0);
        check("perf_md_clr", hz.mdCycles, 32'd0);
`endif
        to_next();

        // Directed vectors checked by the model only.
        apply(5'd4, 5'd6, 0, 5'd4, 5'd6, 5'd0, 0, 0, 5'd4, 1, 0, 5'd6, 1);
        apply(5'd4, 5'd6, 0, 5'd7, 5'd9, 5'd0, 0, 0, 5'd7, 1, 0, 5'd9, 1);
        apply(5'd2, 5'd9, 0, 5'd1, 5'd9, 5'd9, 1, 1, 5'd0, 0, 0, 5'd1, 1);
        apply(5'd2, 5'd9, 1, 5'd1, 5'd3, 5'd0, 0, 0, 5'd9, 1, 1, 5'd0, 0);
        apply(5'd2, 5'd9, 1, 5'd1, 5'd3, 5'd2, 0, 0, 5'd0, 1, 1, 5'd0, 0);
        apply(5'd0, 5'd0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 1, 1, 5'd0, 1);
        apply(5'd31, 5'd30, 1, 5'd30, 5'd31, 5'd31, 1, 0, 5'd30, 1, 0, 5'd31, 1);
        clr();

        // mdStartE held across BUSY: ignored until IDLE, then restarts.
        hz.mdStartE = 1; hz.mdOpE = 0;
        repeat (6) to_next();
        hz.mdStartE = 0;
        hz.memToRegE = 1; hz.RtE = 7; hz.RtD = 7;
        repeat (4) to_next();
        clr();
        repeat (2) to_next();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
